// File: rtl/elastic_reg_pipe_pkg.sv
// Shared types and the stage-0 data transform for the elastic register pipe.
package elastic_reg_pipe_pkg;

  typedef enum logic [1:0] {
    XF_PASS = 2'd0,
    XF_INV  = 2'd1,
    XF_REV  = 2'd2
  } xform_e;

  // Widest data word the transform handles; callers zero-extend and truncate.
  localparam int XF_MAX_W = 64;

  function automatic logic [XF_MAX_W-1:0] xform(input xform_e mode,
                                               input logic [XF_MAX_W-1:0] d,
                                               input int w);
    logic [XF_MAX_W-1:0] r;
    case (mode)
      XF_INV: r = ~d;
      XF_REV: begin
        // Reverse the full word, then slide the live bits back down to [w-1:0].
        r = {<<{d}};
        r = r >> (XF_MAX_W - w);
      end
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/elastic_reg_pipe_stage.sv
// One elastic stage: main register plus skid register, ready driven from state only.
module elastic_reg_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_data
);

  logic             main_vld;
  logic             skid_vld;
  logic [WIDTH-1:0] main_dat;
  logic [WIDTH-1:0] skid_dat;
  logic             take;
  logic             accept;

  assign up_ready = !skid_vld;
  assign dn_valid = main_vld;
  assign dn_data  = main_dat;
  assign take     = main_vld && dn_ready;
  assign accept   = up_valid && !skid_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_dat <= '0;
      skid_dat <= '0;
    end else if (flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (skid_vld) begin
      // Upstream is stalled here, so only the skid-to-main refill can happen.
      if (take) begin
        main_dat <= skid_dat;
        skid_vld <= 1'b0;
      end
    end else if (main_vld && !take) begin
      if (accept) begin
        skid_dat <= up_data;
        skid_vld <= 1'b1;
      end
    end else begin
      main_vld <= accept;
      if (accept) main_dat <= up_data;
    end
  end

endmodule

// File: rtl/elastic_reg_pipe.sv
// Elastic valid/ready register pipe: DEPTH skid-buffered stages, stage-0 transform,
// occupancy count and synchronous flush.
module elastic_reg_pipe
  import elastic_reg_pipe_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 3,
  parameter  int XFORM = 0,
  localparam int CNT_W = $clog2(2*DEPTH+1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic [CNT_W-1:0] OCCUPANCY
);

  localparam xform_e XF_MODE = xform_e'(XFORM[1:0]);

  logic [DEPTH:0]   vld_chain;
  logic [DEPTH:0]   rdy_chain;
  logic [WIDTH-1:0] dat_chain [DEPTH+1];
  logic [CNT_W-1:0] occ;
  logic             in_fire;
  logic             out_fire;

  // Stage 0 entry: transform applied once here, later stages copy verbatim.
  assign vld_chain[0]     = IN_VALID && !FLUSH;
  assign dat_chain[0]     = WIDTH'(xform(XF_MODE, XF_MAX_W'(IN_DATA), WIDTH));
  assign rdy_chain[DEPTH] = OUT_READY && !FLUSH;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    elastic_reg_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (CLK),
      .rst      (RST),
      .flush    (FLUSH),
      .up_valid (vld_chain[i]),
      .up_ready (rdy_chain[i]),
      .up_data  (dat_chain[i]),
      .dn_valid (vld_chain[i+1]),
      .dn_ready (rdy_chain[i+1]),
      .dn_data  (dat_chain[i+1])
    );
  end

  assign IN_READY  = rdy_chain[0] && !FLUSH && !RST;
  assign OUT_VALID = vld_chain[DEPTH] && !FLUSH && !RST;
  assign OUT_DATA  = dat_chain[DEPTH];

  assign in_fire  = IN_VALID && IN_READY;
  assign out_fire = OUT_VALID && OUT_READY;

  // Occupancy tracks words held across all stages.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      occ <= '0;
    end else if (FLUSH) begin
      occ <= '0;
    end else if (in_fire && !out_fire) begin
      occ <= occ + CNT_W'(1);
    end else if (out_fire && !in_fire) begin
      occ <= occ - CNT_W'(1);
    end
  end

  assign OCCUPANCY = occ;

endmodule

// File: tb/tb_elastic_reg_pipe.sv
// Directed and scoreboarded bench for elastic_reg_pipe (DEPTH 3 with three transforms,
// plus DEPTH 1 and DEPTH 5 under random back-pressure).
module tb_elastic_reg_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       in_ready, out_valid;
  logic [7:0] out_data;
  logic [2:0] occ;
  logic       inv_in_ready, inv_out_valid, rev_in_ready, rev_out_valid;
  logic [7:0] inv_out_data, rev_out_data;
  logic [2:0] inv_occ, rev_occ;

  logic       rv  [2];
  logic       rr  [2];
  logic [7:0] rd  [2];
  logic       rin [2];
  logic       rov [2];
  logic [7:0] rq  [2];
  logic [3:0] ro  [2];
  logic [1:0] occ1;
  logic [3:0] occ5;
  logic       rflush;

  assign ro[0] = {2'b00, occ1};
  assign ro[1] = occ5;

  elastic_reg_pipe #(.WIDTH(8), .DEPTH(3), .XFORM(0)) dut (
    .CLK(clk), .RST(rst), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(in_ready),
    .IN_DATA(in_data), .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data),
    .OCCUPANCY(occ));

  elastic_reg_pipe #(.WIDTH(8), .DEPTH(3), .XFORM(1)) dut_inv (
    .CLK(clk), .RST(rst), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(inv_in_ready),
    .IN_DATA(in_data), .OUT_VALID(inv_out_valid), .OUT_READY(out_ready),
    .OUT_DATA(inv_out_data), .OCCUPANCY(inv_occ));

  elastic_reg_pipe #(.WIDTH(8), .DEPTH(3), .XFORM(2)) dut_rev (
    .CLK(clk), .RST(rst), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(rev_in_ready),
    .IN_DATA(in_data), .OUT_VALID(rev_out_valid), .OUT_READY(out_ready),
    .OUT_DATA(rev_out_data), .OCCUPANCY(rev_occ));

  elastic_reg_pipe #(.WIDTH(8), .DEPTH(1), .XFORM(0)) dut_d1 (
    .CLK(clk), .RST(rst), .FLUSH(rflush), .IN_VALID(rv[0]), .IN_READY(rin[0]),
    .IN_DATA(rd[0]), .OUT_VALID(rov[0]), .OUT_READY(rr[0]), .OUT_DATA(rq[0]),
    .OCCUPANCY(occ1));

  elastic_reg_pipe #(.WIDTH(8), .DEPTH(5), .XFORM(0)) dut_d5 (
    .CLK(clk), .RST(rst), .FLUSH(rflush), .IN_VALID(rv[1]), .IN_READY(rin[1]),
    .IN_DATA(rd[1]), .OUT_VALID(rov[1]), .OUT_READY(rr[1]), .OUT_DATA(rq[1]),
    .OCCUPANCY(occ5));

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    rflush = 1'b0;
    for (int k = 0; k < 2; k++) begin rv[k] = 1'b0; rr[k] = 1'b0; rd[k] = 8'h00; end
    #1;
    check("rst_in_ready_low", in_ready, 0);
    check("rst_out_valid_low", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_occ", occ, 0);
    check("rst_in_ready_release", in_ready, 1);
  endtask

  task automatic run_rand(input int k, input string nm);
    logic [7:0] q[$];
    int   sent = 0;
    int   got = 0;
    int   occ_bad = 0;
    logic pend = 1'b0;
    for (int c = 0; c < 20000 && got < 1000; c++) begin
      @(negedge clk);
      if (!pend) begin
        rv[k] = (sent < 1000) && ($urandom_range(0, 3) != 0);
        rd[k] = 8'($urandom);
      end
      rr[k] = 1'($urandom_range(0, 1));
      #1;
      if (32'(ro[k]) != q.size()) occ_bad++;
      if (rov[k] && rr[k]) begin
        if (q.size() == 0) check({nm, "_underflow"}, 1, 0);
        else check({nm, "_data"}, rq[k], q.pop_front());
        got++;
      end
      if (rv[k] && rin[k]) begin
        q.push_back(rd[k]);
        sent++;
      end
      pend = rv[k] && !rin[k];
    end
    @(negedge clk);
    rv[k] = 1'b0;
    rr[k] = 1'b0;
    check({nm, "_words"}, got, 1000);
    check({nm, "_occ_track"}, occ_bad, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, got, acc, acc_cyc, out_cyc, gi, gr, vcount;
    do_reset();

    // Full-rate stream with the consumer always ready.
    sent = 0; got = 0; acc_cyc = -1; out_cyc = -1;
    for (int c = 0; c < 60 && got < 16; c++) begin
      @(negedge clk);
      in_valid = (sent < 16); in_data = 8'(sent + 1); out_ready = 1'b1;
      #1;
      if (out_valid && out_ready) begin
        if (out_cyc < 0) out_cyc = c;
        check("t1_data", out_data, got + 1);
        got++;
      end
      if (c == 5) check("t1_occ_steady", occ, 3);
      if (in_valid && in_ready) begin
        if (acc_cyc < 0) acc_cyc = c;
        sent++;
      end
    end
    check("t1_latency", out_cyc - acc_cyc, 3);
    check("t1_count", got, 16);

    // Back-pressure until full, then drain.
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'(8'h20 + acc); out_ready = 1'b0;
      #1;
      if (in_valid && in_ready) acc++;
    end
    check("t2_accepted", acc, 6);
    check("t2_in_ready_full", in_ready, 0);
    check("t2_occ_full", occ, 6);
    got = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      if (out_valid && out_ready) begin
        check("t2_drain_data", out_data, 8'h20 + got);
        got++;
      end
    end
    check("t2_drained", got, 6);
    check("t2_occ_empty", occ, 0);

    // Transforms on the inverting and bit-reversing instances.
    @(negedge clk); in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b0;
    @(negedge clk); in_data = 8'h01;
    gi = 0; gr = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      if (inv_out_valid) begin
        check("t3_inv", inv_out_data, (gi == 0) ? 8'hC3 : 8'hFE);
        gi++;
      end
      if (rev_out_valid) begin
        check("t3_rev", rev_out_data, (gr == 0) ? 8'h3C : 8'h80);
        gr++;
      end
    end
    check("t3_inv_count", gi, 2);
    check("t3_rev_count", gr, 2);

    // Flush with four words held.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'(8'h11 + c); out_ready = 1'b0;
    end
    @(negedge clk); in_valid = 1'b0;
    #1; check("t4_occ_four", occ, 4);
    @(negedge clk); flush = 1'b1; in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b1;
    #1;
    check("t4_flush_out_valid", out_valid, 0);
    check("t4_flush_in_ready", in_ready, 0);
    @(negedge clk); flush = 1'b0; in_valid = 1'b1; in_data = 8'hA5;
    #1;
    check("t4_occ_cleared", occ, 0);
    check("t4_out_valid_cleared", out_valid, 0);
    check("t4_accept_a5", in_ready, 1);
    out_cyc = -1; got = 0;
    for (int c = 1; c < 12; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        if (got == 0) begin
          check("t4_first_word", out_data, 8'hA5);
          out_cyc = c;
        end
        got++;
      end
    end
    check("t4_first_latency", out_cyc, 3);
    check("t4_single_word", got, 1);

    // Asynchronous reset pulse in the middle of a stream.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'(8'h40 + c); out_ready = 1'b1;
    end
    @(negedge clk);
    #1; check("t5_pre_out_valid", out_valid, 1);
    #2; rst = 1'b1;
    #1;
    check("t5_out_valid_drop", out_valid, 0);
    check("t5_in_ready_drop", in_ready, 0);
    check("t5_occ_zero", occ, 0);
    @(negedge clk);
    #2; rst = 1'b0; in_valid = 1'b0;
    #1; check("t5_in_ready_rise", in_ready, 1);
    vcount = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (out_valid) vcount++;
    end
    check("t5_no_stale", vcount, 0);
    check("t5_occ_after", occ, 0);

    // Random back-pressure on DEPTH 1 and DEPTH 5.
    fork
      run_rand(0, "d1");
      run_rand(1, "d5");
    join

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
